// File: rtl/theremin_osc_gen.sv
// theremin_osc_gen
//   Square-wave generator that stands in for a theremin oscillator when
//   exercising frequency-meter inputs. The full period is a Q INT.FRAC
//   fixed-point number of CLK cycles; the fractional part is carried from
//   half-phase to half-phase so that the long-run period is exact.
//
// Ports
//   CLK           in   system clock, all logic on the rising edge
//   RESET         in   synchronous, active-high reset
//   ENABLE        in   run request; dropping it lets the current period finish
//   PERIOD        in   requested full period, Q PERIOD_INT_BITS.PERIOD_FRAC_BITS
//   PERIOD_VALID  in   PERIOD holds a new value
//   PERIOD_READY  out  one-entry shadow register is empty
//   FREQ_OUT      out  registered square wave, high only in the HIGH phase
//   PERIOD_ERR    out  one-cycle pulse after an accepted period was clamped
//   EDGE_COUNT    out  number of FREQ_OUT rising edges, wraps
module theremin_osc_gen #(
    parameter int PERIOD_INT_BITS  = 16,
    parameter int PERIOD_FRAC_BITS = 8,
    parameter int EDGE_COUNT_BITS  = 16
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic                                        ENABLE,
    input  logic [PERIOD_INT_BITS+PERIOD_FRAC_BITS-1:0] PERIOD,
    input  logic                                        PERIOD_VALID,
    output logic                                        PERIOD_READY,
    output logic                                        FREQ_OUT,
    output logic                                        PERIOD_ERR,
    output logic [EDGE_COUNT_BITS-1:0]                  EDGE_COUNT
);

    localparam int PW = PERIOD_INT_BITS + PERIOD_FRAC_BITS;
    localparam int SW = PW + 1;               // one guard bit: residue + H never overflows
    localparam int CW = PERIOD_INT_BITS + 1;  // integer part of the phase sum
    localparam logic [PW-1:0] MIN_PERIOD = PW'(4) << PERIOD_FRAC_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t                      state;
    logic [PW-1:0]               active_period;
    logic                        active_valid;
    logic [PW-1:0]               shadow_period;
    logic                        shadow_full;
    logic [PERIOD_FRAC_BITS-1:0] residue;
    logic [CW-1:0]               half_count;

    logic                        accept;
    logic                        needs_clamp;
    logic [PW-1:0]               accepted_period;
    logic [PW-1:0]               start_period;
    logic [PW-1:0]               phase_period;
    logic [PERIOD_FRAC_BITS-1:0] phase_residue;
    logic [SW-1:0]               phase_sum;
    logic [CW-1:0]               phase_len;
    logic [PERIOD_FRAC_BITS-1:0] next_residue;
    logic                        phase_done;

    assign PERIOD_READY = ~shadow_full;

    always_comb begin
        accept          = PERIOD_VALID & ~shadow_full;
        // integer part below 4 <=> value below 4.0
        needs_clamp     = (PERIOD < MIN_PERIOD);
        accepted_period = needs_clamp ? MIN_PERIOD : PERIOD;

        // Period for a HIGH phase about to start: a same-cycle acceptance
        // wins, then a pending shadow, else the current active period.
        if (accept) begin
            start_period = accepted_period;
        end else if (shadow_full) begin
            start_period = shadow_period;
        end else begin
            start_period = active_period;
        end

        phase_period  = active_period;
        phase_residue = residue;
        case (state)
            ST_IDLE: begin
                phase_period  = start_period;
                phase_residue = '0;           // residue restarts with each run
            end
            ST_LOW: begin
                phase_period  = start_period;
            end
            default: begin
                phase_period  = active_period;
            end
        endcase

        phase_sum    = {1'b0, phase_period >> 1}
                     + {{(SW-PERIOD_FRAC_BITS){1'b0}}, phase_residue};
        phase_len    = phase_sum[SW-1:PERIOD_FRAC_BITS];
        next_residue = phase_sum[PERIOD_FRAC_BITS-1:0];
        phase_done   = (half_count == '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            FREQ_OUT      <= 1'b0;
            PERIOD_ERR    <= 1'b0;
            EDGE_COUNT    <= '0;
            active_period <= '0;
            active_valid  <= 1'b0;
            shadow_period <= '0;
            shadow_full   <= 1'b0;
            residue       <= '0;
            half_count    <= '0;
        end else begin
            PERIOD_ERR <= accept & needs_clamp;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        active_period <= accepted_period;
                        active_valid  <= 1'b1;
                    end
                    if (ENABLE && active_valid) begin
                        state         <= ST_HIGH;
                        FREQ_OUT      <= 1'b1;
                        EDGE_COUNT    <= EDGE_COUNT + EDGE_COUNT_BITS'(1);
                        active_period <= start_period;
                        shadow_full   <= 1'b0;
                        half_count    <= phase_len - CW'(1);
                        residue       <= next_residue;
                    end
                end

                ST_HIGH: begin
                    if (accept) begin
                        shadow_period <= accepted_period;
                        shadow_full   <= 1'b1;
                    end
                    if (phase_done) begin
                        state      <= ST_LOW;
                        FREQ_OUT   <= 1'b0;
                        half_count <= phase_len - CW'(1);
                        residue    <= next_residue;
                    end else begin
                        half_count <= half_count - CW'(1);
                    end
                end

                ST_LOW: begin
                    if (phase_done && ENABLE) begin
                        // accepted value goes straight to active, bypassing the shadow
                        state         <= ST_HIGH;
                        FREQ_OUT      <= 1'b1;
                        EDGE_COUNT    <= EDGE_COUNT + EDGE_COUNT_BITS'(1);
                        active_period <= start_period;
                        shadow_full   <= 1'b0;
                        half_count    <= phase_len - CW'(1);
                        residue       <= next_residue;
                    end else begin
                        if (accept) begin
                            shadow_period <= accepted_period;
                            shadow_full   <= 1'b1;
                        end
                        if (phase_done) begin
                            state <= ST_IDLE;
                        end else begin
                            half_count <= half_count - CW'(1);
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    FREQ_OUT <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_theremin_osc_gen.sv
// tb_theremin_osc_gen
//   Directed bench for theremin_osc_gen. A timeline model predicts the
//   outputs from absolute edge times (cumulative ideal time, floor at each
//   half-phase boundary) and is compared every cycle; literal expectations
//   for run lengths and pulses pin the model.
module tb_theremin_osc_gen;

    localparam int EB = 8;   // narrow edge counter so wrap is exercised

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          ENABLE = 1'b0;
    logic [23:0]   PERIOD = '0;
    logic          PERIOD_VALID = 1'b0;
    logic          PERIOD_READY;
    logic          FREQ_OUT;
    logic          PERIOD_ERR;
    logic [EB-1:0] EDGE_COUNT;

    int n_total = 0;
    int n_pass  = 0;

    theremin_osc_gen #(
        .PERIOD_INT_BITS (16),
        .PERIOD_FRAC_BITS(8),
        .EDGE_COUNT_BITS (EB)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .PERIOD      (PERIOD),
        .PERIOD_VALID(PERIOD_VALID),
        .PERIOD_READY(PERIOD_READY),
        .FREQ_OUT    (FREQ_OUT),
        .PERIOD_ERR  (PERIOD_ERR),
        .EDGE_COUNT  (EDGE_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- timeline model ----------------
    bit          m_live = 0;
    longint      m_now = 0;      // index of the most recent rising edge
    bit          m_running = 0;
    bit          m_level = 0;
    bit          m_actv = 0;
    int unsigned m_active = 0;
    int unsigned m_shadow[$];
    bit          m_err = 0;
    int unsigned m_edges = 0;
    longint      m_t0 = 0;       // edge at which the current run started
    longint      m_target = 0;   // ideal elapsed time since m_t0, 1/256 cycles
    longint      m_next = 0;     // edge of the next half-phase boundary

    task automatic m_advance();
        m_target += longint'(m_active / 2);
        m_next    = m_t0 + (m_target / 256);
    endtask

    always @(posedge CLK) begin
        bit          acc;
        bit          clampd;
        bit          old_valid;
        int unsigned pv;
        m_now++;
        if (RESET) begin
            m_live = 1; m_running = 0; m_level = 0; m_actv = 0;
            m_shadow.delete(); m_err = 0; m_edges = 0;
        end else begin
            acc    = PERIOD_VALID && (m_shadow.size() == 0);
            pv     = PERIOD;
            clampd = (pv < 4 * 256);
            if (clampd) pv = 4 * 256;
            m_err  = acc && clampd;
            if (!m_running) begin
                old_valid = m_actv;
                if (acc) begin m_active = pv; m_actv = 1; end
                if (ENABLE && old_valid) begin
                    if (m_shadow.size() > 0) m_active = m_shadow.pop_front();
                    m_running = 1; m_level = 1; m_edges++;
                    m_t0 = m_now; m_target = 0;
                    m_advance();
                end
            end else if (m_now == m_next) begin
                if (m_level) begin
                    m_level = 0;
                    m_advance();
                    if (acc) m_shadow.push_back(pv);
                end else if (ENABLE) begin
                    if (acc) m_active = pv;
                    else if (m_shadow.size() > 0) m_active = m_shadow.pop_front();
                    m_level = 1; m_edges++;
                    m_advance();
                end else begin
                    m_running = 0;
                    if (acc) m_shadow.push_back(pv);
                end
            end else if (acc) begin
                m_shadow.push_back(pv);
            end
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            chk("freq_out",     FREQ_OUT,     m_level);
            chk("edge_count",   EDGE_COUNT,   m_edges % (1 << EB));
            chk("period_ready", PERIOD_READY, m_shadow.size() == 0);
            chk("period_err",   PERIOD_ERR,   m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic send(input logic [23:0] p);
        int n = 0;
        while (!PERIOD_READY && n < 200) begin step(); n++; end
        chk("send_ready_timeout", n < 200, 1);
        PERIOD = p; PERIOD_VALID = 1'b1;
        step();
        PERIOD_VALID = 1'b0;
    endtask

    task automatic run_len(input logic lvl, input int bound, output int n);
        n = 0;
        while (FREQ_OUT === lvl && n < bound) begin n++; step(); end
    endtask

    task automatic wait_level(input logic lvl);
        int n = 0;
        while (FREQ_OUT !== lvl && n < 1000) begin step(); n++; end
        chk("wait_level_timeout", n < 1000, 1);
    endtask

    initial begin
        int          n;
        int          k;
        logic [EB-1:0] e0;
        logic [EB-1:0] prev;

        // reset state
        repeat (3) step();
        chk("rst_freq", FREQ_OUT, 0);
        chk("rst_ready", PERIOD_READY, 1);
        chk("rst_edges", EDGE_COUNT, 0);
        chk("rst_err", PERIOD_ERR, 0);
        RESET = 1'b0;
        repeat (5) step();
        chk("idle_no_period", FREQ_OUT, 0);

        // nominal 10.0: first high two cycles after acceptance, 5/5
        ENABLE = 1'b1;
        send(24'h000A00);
        chk("start_delay_low", FREQ_OUT, 0);
        step();
        chk("start_delay_high", FREQ_OUT, 1);
        run_len(1'b1, 50, n); chk("nom_high", n, 5);
        run_len(1'b0, 50, n); chk("nom_low", n, 5);
        e0 = EDGE_COUNT;
        repeat (10) step();
        chk("nom_edge_per_10", EDGE_COUNT - e0, 1);

        // update to 20.0 at cycle 2 of HIGH
        step();
        PERIOD = 24'h001400; PERIOD_VALID = 1'b1;
        step();
        PERIOD_VALID = 1'b0;
        chk("upd_ready_low", PERIOD_READY, 0);
        run_len(1'b1, 50, n); chk("upd_rest_high", n, 3);
        run_len(1'b0, 50, n); chk("upd_old_low", n, 5);
        chk("upd_ready_back", PERIOD_READY, 1);
        run_len(1'b1, 50, n); chk("upd_new_high", n, 10);
        run_len(1'b0, 50, n); chk("upd_new_low", n, 10);

        // ENABLE drop mid-HIGH at 10.0
        send(24'h000A00);
        wait_level(1'b0);
        wait_level(1'b1);
        step(); step();
        ENABLE = 1'b0;
        e0 = EDGE_COUNT;
        run_len(1'b1, 50, n); chk("drop_rest_high", n, 3);
        run_len(1'b0, 40, n); chk("drop_stays_low", n, 40);
        chk("drop_no_edge", EDGE_COUNT, e0);

        // fractional 10.5 accepted in IDLE
        send(24'h000A80);
        ENABLE = 1'b1;
        step();
        chk("frac_start", FREQ_OUT, 1);
        run_len(1'b1, 50, n); chk("frac_ph1", n, 5);
        run_len(1'b0, 50, n); chk("frac_ph2", n, 5);
        run_len(1'b1, 50, n); chk("frac_ph3", n, 5);
        run_len(1'b0, 50, n); chk("frac_ph4", n, 6);
        prev = EDGE_COUNT; k = 0; n = 0;
        while (k < 1000 && n < 20000) begin
            step(); n++;
            if (EDGE_COUNT != prev) k++;
            prev = EDGE_COUNT;
        end
        chk("frac_1000_periods", n, 10500);

        // clamp 2.0 -> 4.0
        ENABLE = 1'b0;
        repeat (30) step();
        send(24'h000200);
        chk("clamp_err_pulse", PERIOD_ERR, 1);
        step();
        chk("clamp_err_once", PERIOD_ERR, 0);
        ENABLE = 1'b1;
        wait_level(1'b1);
        run_len(1'b1, 50, n); chk("clamp_high", n, 2);
        run_len(1'b0, 50, n); chk("clamp_low", n, 2);
        run_len(1'b1, 50, n); chk("clamp_high2", n, 2);

        // acceptance on the LOW->HIGH edge applies to the new HIGH
        step();
        PERIOD = 24'h000600; PERIOD_VALID = 1'b1;
        step();
        PERIOD_VALID = 1'b0;
        chk("same_edge_high", FREQ_OUT, 1);
        run_len(1'b1, 50, n); chk("same_edge_len", n, 3);
        run_len(1'b0, 50, n); chk("same_edge_low", n, 3);

        // reset mid-LOW with EDGE_COUNT = 7
        RESET = 1'b1; step(); RESET = 1'b0;
        send(24'h000A00);
        n = 0;
        while (EDGE_COUNT != 7 && n < 200) begin step(); n++; end
        chk("edge7_timeout", n < 200, 1);
        wait_level(1'b0);
        step(); step();
        RESET = 1'b1;
        step();
        chk("midrst_freq", FREQ_OUT, 0);
        chk("midrst_edges", EDGE_COUNT, 0);
        chk("midrst_ready", PERIOD_READY, 1);
        RESET = 1'b0;
        run_len(1'b0, 30, n); chk("midrst_quiet", n, 30);
        send(24'h000A00);
        chk("restart_low", FREQ_OUT, 0);
        step();
        chk("restart_high", FREQ_OUT, 1);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
